// File: rtl/ifetch_pc_sequencer_pkg.sv
// Shared definitions for the instruction-fetch PC sequencer.
package ifetch_pkg;

  localparam int PC_W = 30;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 30'h0000_0000;

  typedef enum logic {
    FETCH  = 1'b0,
    BR_ADD = 1'b1
  } seq_state_t;

endpackage

// File: rtl/ifetch_pc_sequencer_adder.sv
// 30-bit word-address adder.
// The carry-out is dropped, so every sum wraps modulo 2^30.
module FullAdder30 (
  output logic [29:0] result,
  input  logic [29:0] a,
  input  logic [29:0] b,
  input  logic        cin
);

  // Plain modular add; the top of the sum is discarded by the width
  assign result = a + b + {29'd0, cin};

endmodule

// File: rtl/ifetch_pc_sequencer.sv
// Fetch PC sequencer.
// One shared adder serves two purposes:
//   - PC increment in FETCH
//   - base + offset in BR_ADD
// Jumps load the target directly without using the adder.
module ifetch_pc_sequencer
  import ifetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            jump_req,
  input  logic [PC_W-1:0] jump_target,
  input  logic            branch_req,
  input  logic [PC_W-1:0] branch_imm,
  output logic [PC_W-1:0] pc_out,
  output logic            pc_valid,
  output logic            busy
);

  seq_state_t      state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [PC_W-1:0] base, base_nxt;
  logic [PC_W-1:0] imm_r, imm_nxt;
  logic [PC_W-1:0] add_a, add_b, sum;
  logic            add_cin;

  FullAdder30 u_add (
    .result (sum),
    .a      (add_a),
    .b      (add_b),
    .cin    (add_cin)
  );

  // Adder operand mux, next-state logic and next-PC selection.
  // The increment setup is the default, so the adder inputs are never X.
  always_comb begin
    add_a     = pc;
    add_b     = '0;
    add_cin   = 1'b1;
    pc_nxt    = pc;
    base_nxt  = base;
    imm_nxt   = imm_r;
    state_nxt = state;
    case (state)
      FETCH: begin
        if (stall) begin
          pc_nxt = pc;
        end else if (jump_req) begin
          pc_nxt = jump_target;
        end else if (branch_req) begin
          // Latch PC+1 and the offset.
          // The target add happens next cycle, which creates the bubble.
          base_nxt  = sum;
          imm_nxt   = branch_imm;
          state_nxt = BR_ADD;
        end else begin
          pc_nxt = sum;
        end
      end
      BR_ADD: begin
        add_a     = base;
        add_b     = imm_r;
        add_cin   = 1'b0;
        pc_nxt    = sum;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // State and PC registers.
  // Reset is synchronous and overrides everything, including mid-branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      state <= FETCH;
      base  <= '0;
      imm_r <= '0;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
      base  <= base_nxt;
      imm_r <= imm_nxt;
    end
  end

  assign pc_out   = pc;
  assign pc_valid = (state == FETCH);
  assign busy     = (state == BR_ADD);

endmodule

// File: tb/tb_ifetch_pc_sequencer.sv
// Directed bench for ifetch_pc_sequencer.
// Two instances share the same stimulus:
//   - dut0 uses the default reset PC
//   - dut1 uses reset PC 30'h3FFFFFFF
module tb_ifetch_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, jump_req, branch_req;
  logic [29:0] jump_target, branch_imm;
  logic [29:0] pc0, pc1;
  logic        v0, v1, b0, b1;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ifetch_pc_sequencer dut0 (
    .clk(clk), .reset(reset), .stall(stall), .jump_req(jump_req),
    .jump_target(jump_target), .branch_req(branch_req), .branch_imm(branch_imm),
    .pc_out(pc0), .pc_valid(v0), .busy(b0)
  );

  ifetch_pc_sequencer #(.RESET_PC(30'h3FFF_FFFF)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .jump_req(jump_req),
    .jump_target(jump_target), .branch_req(branch_req), .branch_imm(branch_imm),
    .pc_out(pc1), .pc_valid(v1), .busy(b1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample point sits 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st0(input string tag, input logic [29:0] pc, input logic v, input logic b);
    chk({tag, ".pc"}, {2'b0, pc0}, {2'b0, pc});
    chk({tag, ".valid"}, {31'b0, v0}, {31'b0, v});
    chk({tag, ".busy"}, {31'b0, b0}, {31'b0, b});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; jump_req = 1'b0; branch_req = 1'b0;
    jump_target = '0; branch_imm = '0;

    // 1: reset for two cycles, then free-run
    tick(); tick();
    reset = 1'b0;
    st0("rst", 30'd0, 1'b1, 1'b0);
    chk("rst1.pc", {2'b0, pc1}, 32'h3FFF_FFFF);
    tick(); st0("seq1", 30'd1, 1'b1, 1'b0);
    tick(); st0("seq2", 30'd2, 1'b1, 1'b0);
    tick(); st0("seq3", 30'd3, 1'b1, 1'b0);
    tick(); tick(); st0("seq5", 30'd5, 1'b1, 1'b0);

    // 2: stall beats jump, and the jump is dropped
    stall = 1'b1; jump_req = 1'b1; jump_target = 30'd50;
    tick(); st0("stall1", 30'd5, 1'b1, 1'b0);
    tick(); st0("stall2", 30'd5, 1'b1, 1'b0);
    stall = 1'b0; jump_req = 1'b0;
    tick(); st0("unstall", 30'd6, 1'b1, 1'b0);

    // 3: branch at pc 10 with +4 lands at 10+1+4
    tick(); tick(); tick(); tick(); st0("pc10", 30'd10, 1'b1, 1'b0);
    branch_req = 1'b1; branch_imm = 30'd4;
    tick(); st0("br_bub", 30'd10, 1'b0, 1'b1);
    branch_req = 1'b0;
    tick(); st0("br_tgt", 30'd15, 1'b1, 1'b0);

    // 4: branch -1 from 10 lands back at 10; a jump during BR_ADD is ignored
    jump_req = 1'b1; jump_target = 30'd10;
    tick(); st0("jmp10", 30'd10, 1'b1, 1'b0);
    jump_req = 1'b0; branch_req = 1'b1; branch_imm = 30'h3FFF_FFFF;
    tick(); st0("brm1_bub", 30'd10, 1'b0, 1'b1);
    branch_req = 1'b0; jump_req = 1'b1; jump_target = 30'd200;
    tick(); st0("brm1_tgt", 30'd10, 1'b1, 1'b0);
    jump_req = 1'b0;

    // 5: jump wins over a simultaneous branch, with no bubble
    jump_req = 1'b1; jump_target = 30'd3;
    tick(); st0("jmp3", 30'd3, 1'b1, 1'b0);
    branch_req = 1'b1; branch_imm = 30'd7; jump_target = 30'd100;
    tick(); st0("jmp_br", 30'd100, 1'b1, 1'b0);
    jump_req = 1'b0; branch_req = 1'b0;
    tick(); st0("after_jmp", 30'd101, 1'b1, 1'b0);

    // Negative offset wraps below zero: 0+1-3 = 3FFFFFFE
    jump_req = 1'b1; jump_target = 30'd0;
    tick();
    jump_req = 1'b0; branch_req = 1'b1; branch_imm = 30'h3FFF_FFFD;
    tick(); branch_req = 1'b0;
    tick(); st0("wrap_neg", 30'h3FFF_FFFE, 1'b1, 1'b0);

    // 6: dut1 increments from 3FFFFFFF to 0; reset mid-branch wins
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("r6.pc", {2'b0, pc1}, 32'h3FFF_FFFF);
    chk("r6.valid", {31'b0, v1}, 32'd1);
    tick(); chk("wrap_inc", {2'b0, pc1}, 32'd0);
    branch_req = 1'b1; branch_imm = 30'd5;
    tick(); chk("r6br.busy", {31'b0, b1}, 32'd1);
    branch_req = 1'b0; reset = 1'b1;
    tick(); reset = 1'b0;
    chk("rbr.pc", {2'b0, pc1}, 32'h3FFF_FFFF);
    chk("rbr.valid", {31'b0, v1}, 32'd1);
    chk("rbr.busy", {31'b0, b1}, 32'd0);
    st0("rbr0", 30'd0, 1'b1, 1'b0);
    tick(); chk("rbr.inc", {2'b0, pc1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
